qch_power_ctrl: RTL and testbench

QCH_POWER_CTRL -- requirements
Module: qch_power_ctrl

---
 rtl/qch_pkg.sv | 46 ++++
 rtl/qch_sync.sv | 24 ++
 rtl/qch_power_ctrl.sv | 151 +++++++++++++++
 tb/tb_qch_power_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/qch_pkg.sv
// Shared types for the Q-channel power controller: state encoding and the
// per-state power/handshake output mapping.
package qch_pkg;

  localparam int unsigned STATE_W    = 3;
  localparam int unsigned DENY_CNT_W = 8;

  typedef enum logic [STATE_W-1:0] {
    ST_RUN    = 3'd0,
    ST_REQ    = 3'd1,
    ST_DENY   = 3'd2,
    ST_ISO_ON = 3'd3,
    ST_OFF    = 3'd4,
    ST_PWR_UP = 3'd5,
    ST_EXIT   = 3'd6
  } qch_state_e;

  typedef struct packed {
    logic qreqn;
    logic iso_en;
    logic pwr_en;
  } qch_outs_t;

  // Output levels implied by residing in a given state.
  function automatic qch_outs_t outs_for(input qch_state_e st);
    qch_outs_t o;
    o.qreqn  = 1'b1;
    o.iso_en = 1'b0;
    o.pwr_en = 1'b1;
    case (st)
      ST_REQ: o.qreqn = 1'b0;
      ST_ISO_ON, ST_PWR_UP: begin
        o.qreqn  = 1'b0;
        o.iso_en = 1'b1;
      end
      ST_OFF: begin
        o.qreqn  = 1'b0;
        o.iso_en = 1'b1;
        o.pwr_en = 1'b0;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/qch_sync.sv
// Two-flop synchroniser for a single asynchronous level, with a
// configurable reset value so the idle-safe level is seen out of reset.
module qch_sync #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/qch_power_ctrl.sv
// Q-channel power controller: negotiates quiescence with a device, then
// sequences isolation and power switch off/on around the sleep period.
module qch_power_ctrl
  import qch_pkg::*;
#(
  parameter int unsigned IDLE_THRESH   = 16,
  parameter int unsigned IDLE_W        = 8,
  parameter int unsigned PWR_UP_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  auto_en_i,
  input  logic                  sleep_req_i,
  input  logic                  wake_i,
  input  logic                  qactive_i,
  input  logic                  qacceptn_i,
  input  logic                  qdeny_i,
  output logic                  qreqn_o,
  output logic                  iso_en_o,
  output logic                  pwr_en_o,
  output logic [STATE_W-1:0]    state_o,
  output logic [DENY_CNT_W-1:0] deny_cnt_o
);

  localparam int unsigned PWR_W = (PWR_UP_CYCLES > 1) ? $clog2(PWR_UP_CYCLES) : 1;

  logic qactive_s;
  logic qacceptn_s;
  logic qdeny_s;

  qch_state_e            state;
  qch_state_e            state_n;
  logic [IDLE_W-1:0]     idle_cnt;
  logic [IDLE_W-1:0]     idle_cnt_n;
  logic [PWR_W-1:0]      pwr_cnt;
  logic [PWR_W-1:0]      pwr_cnt_n;
  logic [DENY_CNT_W-1:0] deny_cnt_n;
  qch_outs_t             outs_n;
  logic                  idle_count_en;
  logic                  idle_hit;

  // Device-side handshake signals are asynchronous to clk.
  qch_sync #(.RESET_VAL(1'b1)) u_sync_qactive (
    .clk   (clk),
    .reset (reset),
    .d     (qactive_i),
    .q     (qactive_s)
  );

  qch_sync #(.RESET_VAL(1'b1)) u_sync_qacceptn (
    .clk   (clk),
    .reset (reset),
    .d     (qacceptn_i),
    .q     (qacceptn_s)
  );

  qch_sync #(.RESET_VAL(1'b0)) u_sync_qdeny (
    .clk   (clk),
    .reset (reset),
    .d     (qdeny_i),
    .q     (qdeny_s)
  );

  assign idle_count_en = (state == ST_RUN) && auto_en_i && !qactive_s;
  assign idle_hit      = idle_count_en && (idle_cnt == IDLE_W'(IDLE_THRESH - 1));

  // Next-state, counters and next output levels.
  always_comb begin
    state_n    = state;
    idle_cnt_n = '0;
    pwr_cnt_n  = '0;
    deny_cnt_n = deny_cnt_o;

    if (idle_count_en) begin
      idle_cnt_n = idle_hit ? idle_cnt : idle_cnt + IDLE_W'(1);
    end

    case (state)
      ST_RUN: begin
        if (qacceptn_s && !qdeny_s && (sleep_req_i || idle_hit)) begin
          state_n = ST_REQ;
        end
      end
      ST_REQ: begin
        // Deny wins over accept when both are seen together.
        if (qdeny_s) begin
          state_n = ST_DENY;
          if (deny_cnt_o != {DENY_CNT_W{1'b1}}) begin
            deny_cnt_n = deny_cnt_o + DENY_CNT_W'(1);
          end
        end else if (!qacceptn_s) begin
          state_n = ST_ISO_ON;
        end
      end
      ST_DENY: begin
        if (!qdeny_s) begin
          state_n = ST_RUN;
        end
      end
      ST_ISO_ON: begin
        state_n = ST_OFF;
      end
      ST_OFF: begin
        if (wake_i || qactive_s) begin
          state_n = ST_PWR_UP;
        end
      end
      ST_PWR_UP: begin
        if (pwr_cnt == PWR_W'(PWR_UP_CYCLES - 1)) begin
          state_n = ST_EXIT;
        end else begin
          pwr_cnt_n = pwr_cnt + PWR_W'(1);
        end
      end
      ST_EXIT: begin
        if (qacceptn_s) begin
          state_n = ST_RUN;
        end
      end
      default: begin
        state_n = ST_RUN;
      end
    endcase

    outs_n = outs_for(state_n);
  end

  // State and outputs update on the same edge; reset restores power at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_RUN;
      idle_cnt   <= '0;
      pwr_cnt    <= '0;
      deny_cnt_o <= '0;
      qreqn_o    <= 1'b1;
      iso_en_o   <= 1'b0;
      pwr_en_o   <= 1'b1;
    end else begin
      state      <= state_n;
      idle_cnt   <= idle_cnt_n;
      pwr_cnt    <= pwr_cnt_n;
      deny_cnt_o <= deny_cnt_n;
      qreqn_o    <= outs_n.qreqn;
      iso_en_o   <= outs_n.iso_en;
      pwr_en_o   <= outs_n.pwr_en;
    end
  end

  assign state_o = STATE_W'(state);

endmodule

// File: tb/tb_qch_power_ctrl.sv
// Randomised bench for qch_power_ctrl, checked every cycle against a
// transaction-level reference of the power handshake.
module tb_qch_power_ctrl;

  localparam int unsigned IDLE_THRESH   = 4;
  localparam int unsigned IDLE_W        = 8;
  localparam int unsigned PWR_UP_CYCLES = 3;

  localparam int S_RUN  = 0;
  localparam int S_REQ  = 1;
  localparam int S_DENY = 2;
  localparam int S_ISO  = 3;
  localparam int S_OFF  = 4;
  localparam int S_PUP  = 5;
  localparam int S_EXIT = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       auto_en_i;
  logic       sleep_req_i;
  logic       wake_i;
  logic       qactive_i;
  logic       qacceptn_i;
  logic       qdeny_i;
  logic       qreqn_o;
  logic       iso_en_o;
  logic       pwr_en_o;
  logic [2:0] state_o;
  logic [7:0] deny_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: abstract state, counters and 2-cycle input delay lines.
  int m_state;
  int m_idle;
  int m_up;
  int m_deny;
  bit q_act[$];
  bit q_acc[$];
  bit q_den[$];

  qch_power_ctrl #(
    .IDLE_THRESH   (IDLE_THRESH),
    .IDLE_W        (IDLE_W),
    .PWR_UP_CYCLES (PWR_UP_CYCLES)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .auto_en_i   (auto_en_i),
    .sleep_req_i (sleep_req_i),
    .wake_i      (wake_i),
    .qactive_i   (qactive_i),
    .qacceptn_i  (qacceptn_i),
    .qdeny_i     (qdeny_i),
    .qreqn_o     (qreqn_o),
    .iso_en_o    (iso_en_o),
    .pwr_en_o    (pwr_en_o),
    .state_o     (state_o),
    .deny_cnt_o  (deny_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit e_qreqn(input int st);
    return !(st == S_REQ || st == S_ISO || st == S_OFF || st == S_PUP);
  endfunction

  function automatic bit e_iso(input int st);
    return (st == S_ISO || st == S_OFF || st == S_PUP);
  endfunction

  function automatic bit e_pwr(input int st);
    return (st != S_OFF);
  endfunction

  task automatic model_reset();
    m_state = S_RUN;
    m_idle  = 0;
    m_up    = 0;
    m_deny  = 0;
    q_act   = '{1'b1, 1'b1};
    q_acc   = '{1'b1, 1'b1};
    q_den   = '{1'b0, 1'b0};
  endtask

  // One clock edge of the handshake protocol, using inputs seen two edges ago.
  task automatic model_edge(input bit a_en, input bit sr, input bit wk,
                            input bit act, input bit acc, input bit den);
    bit as;
    bit cs;
    bit ds;
    bit idle_hit;
    int nxt;
    as       = q_act[0];
    cs       = q_acc[0];
    ds       = q_den[0];
    nxt      = m_state;
    idle_hit = (m_state == S_RUN) && a_en && !as && (m_idle == int'(IDLE_THRESH) - 1);
    case (m_state)
      S_RUN:  if (cs && !ds && (sr || idle_hit)) nxt = S_REQ;
      S_REQ: begin
        if (ds) begin
          nxt = S_DENY;
          if (m_deny < 255) m_deny++;
        end else if (!cs) begin
          nxt = S_ISO;
        end
      end
      S_DENY: if (!ds) nxt = S_RUN;
      S_ISO:  nxt = S_OFF;
      S_OFF:  if (wk || as) nxt = S_PUP;
      S_PUP: begin
        m_up++;
        if (m_up == int'(PWR_UP_CYCLES)) nxt = S_EXIT;
      end
      S_EXIT: if (cs) nxt = S_RUN;
      default: nxt = S_RUN;
    endcase
    if (m_state == S_RUN && a_en && !as) begin
      if (m_idle < int'(IDLE_THRESH) - 1) m_idle++;
    end else begin
      m_idle = 0;
    end
    if (nxt != S_PUP) m_up = 0;
    m_state = nxt;
    q_act.push_back(act); void'(q_act.pop_front());
    q_acc.push_back(acc); void'(q_acc.pop_front());
    q_den.push_back(den); void'(q_den.pop_front());
  endtask

  task automatic compare_all();
    check_eq("state",    32'(state_o),     32'(m_state));
    check_eq("qreqn",    32'(qreqn_o),     32'(e_qreqn(m_state)));
    check_eq("iso_en",   32'(iso_en_o),    32'(e_iso(m_state)));
    check_eq("pwr_en",   32'(pwr_en_o),    32'(e_pwr(m_state)));
    check_eq("deny_cnt", 32'(deny_cnt_o),  32'(m_deny));
    check_eq("idle_cnt", 32'(dut.idle_cnt), 32'(m_idle));
  endtask

  // Drive one cycle of inputs, clock, update the reference, then compare.
  task automatic step(input bit a_en, input bit sr, input bit wk,
                      input bit act, input bit acc, input bit den);
    auto_en_i   = a_en;
    sleep_req_i = sr;
    wake_i      = wk;
    qactive_i   = act;
    qacceptn_i  = acc;
    qdeny_i     = den;
    @(posedge clk);
    model_edge(a_en, sr, wk, act, acc, den);
    #1;
    compare_all();
  endtask

  // Assert reset between edges and require outputs to recover without a clock.
  task automatic apply_reset();
    #2;
    reset = 1'b1;
    #1;
    check_eq("rst_state", 32'(state_o),    32'(S_RUN));
    check_eq("rst_pwr",   32'(pwr_en_o),   32'd1);
    check_eq("rst_iso",   32'(iso_en_o),   32'd0);
    check_eq("rst_qreqn", 32'(qreqn_o),    32'd1);
    check_eq("rst_deny",  32'(deny_cnt_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    bit a_en, sr, wk, act, acc, den;
    int extra;
    reset       = 1'b0;
    auto_en_i   = 1'b0;
    sleep_req_i = 1'b0;
    wake_i      = 1'b0;
    qactive_i   = 1'b1;
    qacceptn_i  = 1'b1;
    qdeny_i     = 1'b0;
    model_reset();
    apply_reset();

    // Short idle burst must not reach the auto-sleep threshold.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    check_eq("idle_intr_state", 32'(state_o),      32'(S_RUN));
    check_eq("idle_intr_cnt",   32'(dut.idle_cnt), 32'd0);

    // Random traffic with a device that mostly follows the handshake.
    for (int i = 0; i < 4000; i++) begin
      a_en = ($urandom_range(0, 3) != 0);
      sr   = ($urandom_range(0, 15) == 0);
      wk   = ($urandom_range(0, 15) == 0);
      act  = ($urandom_range(0, 4) == 0);
      den  = !e_qreqn(m_state) && ($urandom_range(0, 5) == 0);
      acc  = ($urandom_range(0, 9) == 0) ? !e_qreqn(m_state) : e_qreqn(m_state);
      step(a_en, sr, wk, act, acc, den);
    end

    // Drive into OFF, then reset asynchronously while powered down.
    apply_reset();
    for (int i = 0; i < 60 && m_state != S_OFF; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b0, e_qreqn(m_state), 1'b0);
    end
    check_eq("reach_off", 32'(state_o), 32'(S_OFF));
    apply_reset();

    // Deny every request until the counter saturates, then a few more.
    extra = 0;
    for (int i = 0; i < 3000 && extra < 30; i++) begin
      step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, !e_qreqn(m_state));
      if (m_deny == 255) extra++;
    end
    check_eq("deny_sat", 32'(deny_cnt_o), 32'd255);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
